// File: rtl/dma_line_responder_pkg.sv
// Shared types for the host-side DMA line responder.
// Holds the default geometry, the responder state encoding, the opcode
// enum shared with mem_ctrl, and the line offset helper.
package dma_line_responder_pkg;

  localparam int CL_SIZE_WIDTH_DEF = 512;
  localparam int ADDR_BITCOUNT_DEF = 64;
  localparam int MEM_LINES_DEF     = 64;
  localparam int INIT_DELAY_DEF    = 4;
  localparam int RD_LATENCY_DEF    = 3;

  // Responder sequencing: startup, then one line transfer at a time.
  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_RD_VALID = 3'd3,
    ST_WR_OPEN  = 3'd4
  } dma_state_t;

  // Opcode encoding used by mem_ctrl when it issues host transfers.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd3
  } dma_opcode_t;

  // Number of byte-address bits that select a byte inside one cache line.
  function automatic int line_offs(input int cl_size_width);
    return $clog2(cl_size_width / 8);
  endfunction

endpackage

// File: rtl/dma_line_responder_if.sv
// Cache-line handshake between mem_ctrl (master) and the host DMA endpoint (slave).
// Requests are levels (rgo/wgo); data hand-off is by pulses (re/we).
// The slave answers with ready levels, the read data bus and an out-of-range pulse.
interface dma_line_responder_if #(
  parameter int CL_SIZE_WIDTH = 512,
  parameter int ADDR_BITCOUNT = 64
);
  logic [ADDR_BITCOUNT-1:0] address;
  logic                     host_rgo;
  logic                     host_wgo;
  logic                     host_re;
  logic                     host_we;
  logic [CL_SIZE_WIDTH-1:0] host_data_bus_write_out;
  logic                     host_init;
  logic                     host_rd_ready;
  logic                     host_wr_ready;
  logic [CL_SIZE_WIDTH-1:0] host_data_bus_read_in;
  logic                     err_oob;

  modport master (
    output address, host_rgo, host_wgo, host_re, host_we, host_data_bus_write_out,
    input  host_init, host_rd_ready, host_wr_ready, host_data_bus_read_in, err_oob
  );

  modport slave (
    input  address, host_rgo, host_wgo, host_re, host_we, host_data_bus_write_out,
    output host_init, host_rd_ready, host_wr_ready, host_data_bus_read_in, err_oob
  );
endinterface

// File: rtl/dma_line_responder_line_ram.sv
// Line-granular backing store, one port shared by reads and writes.
// Latency: write lands on the clock edge, read data is combinational.
// Backpressure: none; contents survive reset.
module dma_line_responder_line_ram #(
  parameter int LINES = 64,
  parameter int WIDTH = 512
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(LINES)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [LINES];

  // Synchronous line write; no reset so the store keeps its contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dma_line_responder.sv
// Host DMA endpoint answering mem_ctrl's line handshake from a local store.
// Latency: host_init INIT_DELAY cycles after reset; read data RD_LATENCY cycles after accept.
// Backpressure: one transfer outstanding; requests wait in IDLE, read wins over write.
module dma_line_responder
  import dma_line_responder_pkg::*;
#(
  parameter int CL_SIZE_WIDTH = CL_SIZE_WIDTH_DEF,
  parameter int ADDR_BITCOUNT = ADDR_BITCOUNT_DEF,
  parameter int MEM_LINES     = MEM_LINES_DEF,
  parameter int INIT_DELAY    = INIT_DELAY_DEF,
  parameter int RD_LATENCY    = RD_LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dma_line_responder_if.slave  bus_if
);

  localparam int OFFS   = line_offs(CL_SIZE_WIDTH);
  localparam int LINE_W = $clog2(MEM_LINES);
  localparam int CNT_W  = $clog2(INIT_DELAY + 1);
  localparam int LAT_W  = $clog2(RD_LATENCY + 1);

  if (MEM_LINES < 2 || (MEM_LINES & (MEM_LINES - 1)) != 0) begin : g_bad_lines
    $error("MEM_LINES must be a power of two and at least 2");
  end
  if (INIT_DELAY < 1) begin : g_bad_init
    $error("INIT_DELAY must be at least 1");
  end
  if (RD_LATENCY < 1) begin : g_bad_lat
    $error("RD_LATENCY must be at least 1");
  end

  dma_state_t               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic [LINE_W-1:0]        rd_idx_q, rd_idx_d;
  logic                     rd_oob_q, rd_oob_d;
  logic [CL_SIZE_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                     init_q, init_d;
  logic                     err_q, err_d;

  logic [ADDR_BITCOUNT-1:0] line_full;
  logic                     cur_in_range;
  logic [LINE_W-1:0]        cur_line;
  logic                     ram_we;
  logic [LINE_W-1:0]        ram_addr;
  logic [CL_SIZE_WIDTH-1:0] ram_rdata;

  // The whole line index takes part in the range check so that far
  // addresses never alias onto a valid line through the low index bits.
  assign line_full    = bus_if.address >> OFFS;
  assign cur_in_range = line_full < ADDR_BITCOUNT'(MEM_LINES);
  assign cur_line     = line_full[LINE_W-1:0];

  // Writes use the address present on the commit cycle; reads use the latched index.
  assign ram_addr = (state_q == ST_WR_OPEN) ? cur_line : rd_idx_q;

  dma_line_responder_line_ram #(
    .LINES (MEM_LINES),
    .WIDTH (CL_SIZE_WIDTH)
  ) u_line_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (bus_if.host_data_bus_write_out),
    .rdata_o (ram_rdata)
  );

  // Next-state, store write enable and error pulse for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    rd_idx_d  = rd_idx_q;
    rd_oob_d  = rd_oob_q;
    rd_data_d = rd_data_q;
    init_d    = init_q;
    err_d     = 1'b0;
    ram_we    = 1'b0;

    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(INIT_DELAY - 1)) begin
          init_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (bus_if.host_rgo) begin
          rd_idx_d = cur_line;
          rd_oob_d = ~cur_in_range;
          lat_d    = LAT_W'(RD_LATENCY - 1);
          state_d  = ST_RD_WAIT;
        end else if (bus_if.host_wgo) begin
          state_d = ST_WR_OPEN;
        end
      end

      ST_RD_WAIT: begin
        if (lat_q != '0) begin
          lat_d = lat_q - 1'b1;
        end else begin
          if (rd_oob_q) begin
            rd_data_d = '0;
            err_d     = 1'b1;
          end else begin
            rd_data_d = ram_rdata;
          end
          state_d = ST_RD_VALID;
        end
      end

      ST_RD_VALID: begin
        if (bus_if.host_re) begin
          state_d = ST_IDLE;
        end
      end

      ST_WR_OPEN: begin
        if (bus_if.host_we) begin
          if (cur_in_range) begin
            ram_we = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (!bus_if.host_wgo) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Sequencer registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      lat_q     <= '0;
      rd_idx_q  <= '0;
      rd_oob_q  <= 1'b0;
      rd_data_q <= '0;
      init_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      rd_idx_q  <= rd_idx_d;
      rd_oob_q  <= rd_oob_d;
      rd_data_q <= rd_data_d;
      init_q    <= init_d;
      err_q     <= err_d;
    end
  end

  assign bus_if.host_init             = init_q;
  assign bus_if.host_rd_ready         = (state_q == ST_RD_VALID);
  assign bus_if.host_wr_ready         = (state_q == ST_WR_OPEN);
  assign bus_if.host_data_bus_read_in = rd_data_q;
  assign bus_if.err_oob               = err_q;

endmodule
